vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator feeding every sprite renderer in the video path.
- Produces the pixel coordinates DrawX/DrawY, the active-video flag blank, and active-low hs/vs sync for the monitor.
- Also produces a one-cycle frame_start pulse and a wrapping frame counter, which animation and sprite-position logic use to step once per frame.
- Default timing is 640x480 @ 60 Hz on the 25 MHz vga_clk.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- FCNT_W, 8, width of frame_count

Ports:
- vga_clk  input  1  pixel clock, all logic on its rising edge
- reset_n  input  1  asynchronous active-low reset
- DrawX  output  10  current horizontal counter, 0..H_TOTAL-1
- DrawY  output  10  current vertical counter, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
- hs  output  1  horizontal sync, active low
- vs  output  1  vertical sync, active low
- line_end  output  1  1 for the single cycle where DrawX==H_TOTAL-1
- frame_start  output  1  1 for the single cycle after wrap where counters equal (0,0)
- frame_count  output  FCNT_W  number of completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525). Both must fit in 10 bits.
- Reset: asserting reset_n low immediately (asynchronously) sets:
  - DrawX=0, DrawY=0, blank=1, hs=1, vs=1
  - line_end=0, frame_start=0, frame_count=0
- Reset mid-frame: the same values apply regardless of position. Counting resumes from (0,0) on the first rising edge after release. No frame_start is emitted for the post-reset frame.
- Horizontal counter: increments every clock. At H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- Vertical counter: at V_TOTAL-1, combined with a horizontal wrap, it wraps to 0.
- Alignment: all outputs are registered. Every output reflects the counter pair currently on DrawX/DrawY, with no skew. They are computed from next-state counter values so they update on the same edge as the counters.
- hs: 0 iff H_VISIBLE+H_FRONT <= DrawX < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
- vs: 0 iff V_VISIBLE+V_FRONT <= DrawY < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for all DrawX on those lines.
- blank: 1 iff DrawX<H_VISIBLE and DrawY<V_VISIBLE. This signal is the gate downstream renderers use to drive colour.
- line_end: high exactly when DrawX==H_TOTAL-1, on every line including vertical blanking.
- frame_start: high for exactly the one cycle where the counters are (0,0) following a wrap from (H_TOTAL-1, V_TOTAL-1). It is 0 on every other cycle.
- frame_count: increments on that same edge (the edge on which frame_start goes high). It wraps from 2^FCNT_W-1 to 0 with no flag.
- Period: one frame equals H_TOTAL*V_TOTAL clocks (default 420000). There are no stalls and no inputs besides clock and reset.
- Out-of-range states are impossible by construction. Any counter value at or above its total wraps to 0 on the next edge.

Test Plan:
- Reset check: hold reset_n=0 for 5 clocks, then release. At release: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, frame_count=0. After 1 edge: DrawX=1.
- hs timing: first line after reset. hs falls on the cycle with DrawX=656 and rises at DrawX=752 (96 cycles low). blank=0 from DrawX=640 through 799. line_end=1 only at DrawX=799.
- vs timing: vs=0 for exactly 1600 cycles, spanning DrawY=490 DrawX=0 through DrawY=491 DrawX=799. blank stays 0 for all DrawY>=480.
- Frame wrap: after 420000 clocks from release, counters read (0,0), frame_start=1 for one cycle, and frame_count=1. Run 3 frames and check exactly 3 frame_start pulses, spaced 420000 apart.
- frame_count wrap: force 256 frames (or set FCNT_W=2 and run 4 frames). The count reads 255 then 0 (or 3 then 0).
- Mid-frame reset: assert reset_n at DrawX=300, DrawY=200, asynchronously between edges. Outputs return to reset values without waiting for a clock edge. After release, the next frame_start arrives 420000 clocks later, and frame_count is 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running horizontal/vertical counters plus
// registered blank, sync, line_end, frame_start and frame counter outputs.
// Every output is computed from the next counter values, so all of them
// change on the same edge as DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FCNT_W    = 8
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  output logic [9:0]        DrawX,
  output logic [9:0]        DrawY,
  output logic              blank,
  output logic              hs,
  output logic              vs,
  output logic              line_end,
  output logic              frame_start,
  output logic [FCNT_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Boundaries held at counter width so every compare is 10-bit vs 10-bit.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]        r_hCount;
  logic [9:0]        r_vCount;
  logic              r_blank;
  logic              r_hs;
  logic              r_vs;
  logic              r_lineEnd;
  logic              r_frameStart;
  logic [FCNT_W-1:0] r_frameCount;

  logic [9:0]        w_hNext;
  logic [9:0]        w_vNext;
  logic              w_hWrap;
  logic              w_frameWrap;
  logic              w_blankNext;
  logic              w_hsNext;
  logic              w_vsNext;
  logic              w_lineEndNext;

  // Next counter values; anything at or past its last value returns to 0,
  // and only a genuine (H_LAST, V_LAST) wrap counts as a new frame.
  always_comb begin
    w_hWrap     = (r_hCount >= H_LAST);
    w_frameWrap = (r_hCount == H_LAST) && (r_vCount == V_LAST);
    w_hNext     = w_hWrap ? 10'd0 : r_hCount + 10'd1;
    w_vNext     = r_vCount;
    if (r_vCount > V_LAST) begin
      w_vNext = 10'd0;
    end else if (w_hWrap) begin
      w_vNext = (r_vCount == V_LAST) ? 10'd0 : r_vCount + 10'd1;
    end
  end

  // Decode the next position so the registered flags line up with it.
  always_comb begin
    w_blankNext   = (w_hNext < H_VIS_END) && (w_vNext < V_VIS_END);
    w_hsNext      = !((w_hNext >= HS_START) && (w_hNext < HS_END));
    w_vsNext      = !((w_vNext >= VS_START) && (w_vNext < VS_END));
    w_lineEndNext = (w_hNext == H_LAST);
  end

  // Counter and output registers, cleared asynchronously to the (0,0) state.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hCount     <= '0;
      r_vCount     <= '0;
      r_blank      <= 1'b1;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_lineEnd    <= 1'b0;
      r_frameStart <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_hCount     <= w_hNext;
      r_vCount     <= w_vNext;
      r_blank      <= w_blankNext;
      r_hs         <= w_hsNext;
      r_vs         <= w_vsNext;
      r_lineEnd    <= w_lineEndNext;
      r_frameStart <= w_frameWrap;
      if (w_frameWrap) begin
        r_frameCount <= r_frameCount + 1'b1;
      end
    end
  end

  assign DrawX       = r_hCount;
  assign DrawY       = r_vCount;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_end    = r_lineEnd;
  assign frame_start = r_frameStart;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster
// (15 clocks per line, 10 lines per frame, 2-bit frame counter) so that
// several frames and a frame-counter wrap fit in a short run.
module tb_vga_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int FW = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [9:0]    x;
    logic [9:0]    y;
    logic          blank;
    logic          hs;
    logic          vs;
    logic          le;
    logic          fs;
    logic [FW-1:0] fc;
  } outs_t;

  typedef struct {
    bit    doReset;
    int    advance;
    outs_t exp;
  } vec_t;

  logic          vgaClk;
  logic          resetN;
  logic [9:0]    drawX;
  logic [9:0]    drawY;
  logic          blankO;
  logic          hsO;
  logic          vsO;
  logic          lineEnd;
  logic          frameStart;
  logic [FW-1:0] frameCount;

  int checks   = 0;
  int failures = 0;

  outs_t sbQueue[$];
  int    sbRemain = 0;
  int    sbEdge   = 0;
  int    pulseEdges[$];
  int    mX, mY, mFc;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .FCNT_W(FW)
  ) dut (
    .vga_clk    (vgaClk),
    .reset_n    (resetN),
    .DrawX      (drawX),
    .DrawY      (drawY),
    .blank      (blankO),
    .hs         (hsO),
    .vs         (vsO),
    .line_end   (lineEnd),
    .frame_start(frameStart),
    .frame_count(frameCount)
  );

  // 10-time-unit pixel clock
  initial vgaClk = 1'b0;
  always #5 vgaClk = ~vgaClk;

  function automatic outs_t sampleDut();
    outs_t s;
    s.x = drawX; s.y = drawY; s.blank = blankO; s.hs = hsO; s.vs = vsO;
    s.le = lineEnd; s.fs = frameStart; s.fc = frameCount;
    return s;
  endfunction

  function automatic outs_t mkOut(int x, int y, bit b, bit h, bit v, bit le, bit fs, int fc);
    outs_t o;
    o.x = 10'(x); o.y = 10'(y); o.blank = b; o.hs = h; o.vs = v;
    o.le = le; o.fs = fs; o.fc = FW'(fc);
    return o;
  endfunction

  function automatic vec_t mkVec(bit r, int adv, outs_t e);
    vec_t v;
    v.doReset = r; v.advance = adv; v.exp = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b le=%b fs=%b fc=%0d",
               name, act.x, act.y, act.blank, act.hs, act.vs, act.le, act.fs, act.fc,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.le, exp.fs, exp.fc);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Either a full reset pulse (ending between edges just after release)
  // or a number of clock edges, leaving the bench 1 unit past the last edge.
  task automatic applyStimulus(input bit doReset, input int advance);
    if (doReset) begin
      @(negedge vgaClk);
      resetN = 1'b0;
      repeat (5) @(posedge vgaClk);
      @(negedge vgaClk);
      resetN = 1'b1;
    end else begin
      repeat (advance) begin
        @(posedge vgaClk);
      end
      #1;
    end
  endtask

  // Reference raster model: steps one position per edge and pushes the
  // outputs expected after that edge.
  always @(posedge vgaClk) begin
    if (sbRemain > 0) begin
      bit fs;
      fs = 1'b0;
      if (mX == HT - 1) begin
        mX = 0;
        if (mY == VT - 1) begin
          mY = 0;
          mFc = (mFc + 1) % (1 << FW);
          fs = 1'b1;
        end else begin
          mY = mY + 1;
        end
      end else begin
        mX = mX + 1;
      end
      sbQueue.push_back(mkOut(mX, mY,
                              (mX < HV) && (mY < VV),
                              !((mX >= HV + HF) && (mX < HV + HF + HS)),
                              !((mY >= VV + VF) && (mY < VV + VF + VS)),
                              mX == HT - 1, fs, mFc));
      sbEdge++;
      sbRemain--;
    end
  end

  // Compare DUT against the scoreboard away from the active edge.
  always @(negedge vgaClk) begin
    while (sbQueue.size() > 0) begin
      outs_t e;
      e = sbQueue.pop_front();
      checkOutput($sformatf("scoreboard edge %0d", sbEdge), sampleDut(), e);
      if (frameStart) pulseEdges.push_back(sbEdge);
    end
  end

  vec_t vecs[20];

  initial begin
    int found;
    int edges;

    resetN = 1'b0;

    // Cumulative walk through the small raster from reset.
    vecs[0]  = mkVec(1, 0,   mkOut(0,  0, 1, 1, 1, 0, 0, 0));
    vecs[1]  = mkVec(0, 1,   mkOut(1,  0, 1, 1, 1, 0, 0, 0));
    vecs[2]  = mkVec(0, 7,   mkOut(8,  0, 0, 1, 1, 0, 0, 0));
    vecs[3]  = mkVec(0, 2,   mkOut(10, 0, 0, 0, 1, 0, 0, 0));
    vecs[4]  = mkVec(0, 2,   mkOut(12, 0, 0, 0, 1, 0, 0, 0));
    vecs[5]  = mkVec(0, 1,   mkOut(13, 0, 0, 1, 1, 0, 0, 0));
    vecs[6]  = mkVec(0, 1,   mkOut(14, 0, 0, 1, 1, 1, 0, 0));
    vecs[7]  = mkVec(0, 1,   mkOut(0,  1, 1, 1, 1, 0, 0, 0));
    vecs[8]  = mkVec(0, 75,  mkOut(0,  6, 0, 1, 1, 0, 0, 0));
    vecs[9]  = mkVec(0, 15,  mkOut(0,  7, 0, 1, 0, 0, 0, 0));
    vecs[10] = mkVec(0, 14,  mkOut(14, 7, 0, 1, 0, 1, 0, 0));
    vecs[11] = mkVec(0, 15,  mkOut(14, 8, 0, 1, 0, 1, 0, 0));
    vecs[12] = mkVec(0, 1,   mkOut(0,  9, 0, 1, 1, 0, 0, 0));
    vecs[13] = mkVec(0, 14,  mkOut(14, 9, 0, 1, 1, 1, 0, 0));
    vecs[14] = mkVec(0, 1,   mkOut(0,  0, 1, 1, 1, 0, 1, 1));
    vecs[15] = mkVec(0, 1,   mkOut(1,  0, 1, 1, 1, 0, 0, 1));
    vecs[16] = mkVec(0, 149, mkOut(0,  0, 1, 1, 1, 0, 1, 2));
    vecs[17] = mkVec(0, 150, mkOut(0,  0, 1, 1, 1, 0, 1, 3));
    vecs[18] = mkVec(0, 150, mkOut(0,  0, 1, 1, 1, 0, 1, 0));
    vecs[19] = mkVec(0, 1,   mkOut(1,  0, 1, 1, 1, 0, 0, 0));

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].doReset, vecs[i].advance);
      checkOutput($sformatf("vector %0d", i), sampleDut(), vecs[i].exp);
    end

    // Three full frames against the reference model.
    applyStimulus(1, 0);
    mX = 0; mY = 0; mFc = 0; sbEdge = 0;
    pulseEdges.delete();
    sbRemain = 3 * FRAME;
    found = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge vgaClk);
      #1;
      if (sbRemain == 0 && sbQueue.size() == 0) begin
        found = 1;
        break;
      end
    end
    if (found == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard drain: timed out with %0d left", sbRemain);
    end
    checkInt("frame_start pulse count", pulseEdges.size(), 3);
    for (int i = 0; i < pulseEdges.size() && i < 3; i++) begin
      checkInt($sformatf("frame_start pulse %0d edge", i), pulseEdges[i], (i + 1) * FRAME);
    end

    // Mid-frame asynchronous reset at (3,2).
    applyStimulus(1, 0);
    applyStimulus(0, 2 * HT + 3);
    checkOutput("pre-reset position", sampleDut(), mkOut(3, 2, 1, 1, 1, 0, 0, 0));
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("async reset immediate", sampleDut(), mkOut(0, 0, 1, 1, 1, 0, 0, 0));
    repeat (2) @(posedge vgaClk);
    @(negedge vgaClk);
    resetN = 1'b1;
    #1;
    checkOutput("after mid-frame release", sampleDut(), mkOut(0, 0, 1, 1, 1, 0, 0, 0));
    found = 0;
    edges = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(posedge vgaClk);
      #1;
      edges++;
      if (frameStart) begin
        found = 1;
        break;
      end
    end
    if (found == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL post-reset frame_start: none within %0d edges", 3 * FRAME);
    end else begin
      checkInt("post-reset frame_start distance", edges, FRAME);
      checkInt("post-reset frame_count", int'(frameCount), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
